// File: rtl/collision_pkg.sv
// Shared types and constants for the collision probe path.
package collision_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } probe_state_t;

    localparam logic [3:0] WALL_CODE = 4'h1;

    localparam int CITY_MAP_W = 320;
    localparam int CITY_MAP_H = 240;
    localparam int GYM_MAP_W  = 200;
    localparam int GYM_MAP_H  = 100;
endpackage

// File: rtl/collision_addr_gen.sv
// Combinational corner mapper: (top-left position, corner index) -> (RAM address, out-of-bounds flag).
// Corner bit 0 selects the right edge, bit 1 selects the bottom edge.
module collision_addr_gen #(
    parameter int MAP_W  = 320,
    parameter int MAP_H  = 240,
    parameter int HB_W   = 16,
    parameter int HB_H   = 16,
    parameter int ADDR_W = 17
) (
    input  logic [9:0]        pos_x,
    input  logic [8:0]        pos_y,
    input  logic [1:0]        corner,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);
    localparam logic [10:0] XOFF = 11'(HB_W - 1);
    localparam logic [9:0]  YOFF = 10'(HB_H - 1);
    localparam logic [10:0] MW   = 11'(MAP_W);
    localparam logic [9:0]  MH   = 10'(MAP_H);

    logic [10:0] cx;
    logic [9:0]  cy;

    // Widened corner sums so the hitbox offset can never wrap.
    always_comb begin
        cx   = {1'b0, pos_x} + (corner[0] ? XOFF : 11'd0);
        cy   = {1'b0, pos_y} + (corner[1] ? YOFF : 10'd0);
        oob  = (cx >= MW) || (cy >= MH);
        addr = oob ? '0 : (ADDR_W'(cy) * ADDR_W'(MAP_W) + ADDR_W'(cx));
    end
endmodule

// File: rtl/collision_probe_sequencer.sv
// Issues four hitbox-corner reads to the collision RAM and folds the returned
// tile codes into a blocked verdict and first event code, with fixed latency 6.
module collision_probe_sequencer
    import collision_pkg::*;
#(
    parameter int         MAP_W     = collision_pkg::CITY_MAP_W,
    parameter int         MAP_H     = collision_pkg::CITY_MAP_H,
    parameter int         HB_W      = 16,
    parameter int         HB_H      = 16,
    parameter int         ADDR_W    = 17,
    parameter logic [3:0] WALL_CODE = collision_pkg::WALL_CODE
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic [9:0]        pos_x,
    input  logic [8:0]        pos_y,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [3:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic              blocked,
    output logic [3:0]        event_code
);
    probe_state_t      state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [9:0]        px_q, px_d;
    logic [8:0]        py_q, py_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              vld_q, vld_d;
    logic              oob_q, oob_d;
    logic              samp_vld_q, samp_oob_q;
    logic              blocked_q, blocked_d;
    logic [3:0]        event_q, event_d;
    logic              clr;

    logic [9:0]        ag_x;
    logic [8:0]        ag_y;
    logic [1:0]        ag_c;
    logic [ADDR_W-1:0] ag_addr;
    logic              ag_oob;

    collision_addr_gen #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H),
        .HB_W  (HB_W),
        .HB_H  (HB_H),
        .ADDR_W(ADDR_W)
    ) u_addr_gen (
        .pos_x (ag_x),
        .pos_y (ag_y),
        .corner(ag_c),
        .addr  (ag_addr),
        .oob   (ag_oob)
    );

    // Next state; the mapper always looks one corner ahead of the registered address,
    // so in IDLE it sees the live inputs for corner 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        px_d    = px_q;
        py_d    = py_q;
        vld_d   = 1'b0;
        clr     = 1'b0;
        ag_x    = px_q;
        ag_y    = py_q;
        ag_c    = cnt_q + 2'd1;
        case (state_q)
            IDLE: begin
                ag_x = pos_x;
                ag_y = pos_y;
                ag_c = 2'd0;
                if (start) begin
                    state_d = ISSUE;
                    cnt_d   = 2'd0;
                    px_d    = pos_x;
                    py_d    = pos_y;
                    vld_d   = 1'b1;
                    clr     = 1'b1;
                end
            end
            ISSUE: begin
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                    vld_d = 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rd_addr_d = vld_d ? ag_addr : '0;
        oob_d     = vld_d & ag_oob;
    end

    // Fold each returned sample into the verdict; OOB samples contribute only their flag.
    always_comb begin
        blocked_d = blocked_q;
        event_d   = event_q;
        if (clr) begin
            blocked_d = 1'b0;
            event_d   = 4'd0;
        end else if (samp_vld_q) begin
            blocked_d = blocked_q | samp_oob_q | (!samp_oob_q && rd_data == WALL_CODE);
            if (event_q == 4'd0 && !samp_oob_q && rd_data >= 4'd2)
                event_d = rd_data;
        end
    end

    // State, address and one-stage valid/OOB pipeline matching the RAM read latency.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            px_q       <= '0;
            py_q       <= '0;
            rd_addr_q  <= '0;
            vld_q      <= 1'b0;
            oob_q      <= 1'b0;
            samp_vld_q <= 1'b0;
            samp_oob_q <= 1'b0;
            blocked_q  <= 1'b0;
            event_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            px_q       <= px_d;
            py_q       <= py_d;
            rd_addr_q  <= rd_addr_d;
            vld_q      <= vld_d;
            oob_q      <= oob_d;
            samp_vld_q <= vld_q;
            samp_oob_q <= oob_q;
            blocked_q  <= blocked_d;
            event_q    <= event_d;
        end
    end

    assign rd_addr    = rd_addr_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign blocked    = blocked_q;
    assign event_code = event_q;
endmodule

// File: tb/tb_collision_probe_sequencer.sv
// Bench for collision_probe_sequencer: synchronous RAM model, corner-rule reference
// model, directed scenarios and randomized probes.
module tb_collision_probe_sequencer;
    localparam int MW = 320;
    localparam int MH = 240;
    localparam int MSZ = MW * MH;

    logic        Clk;
    logic        Reset_n;
    logic        start;
    logic [9:0]  pos_x;
    logic [8:0]  pos_y;
    logic [16:0] rd_addr;
    logic [3:0]  rd_data;
    logic        busy, done, blocked;
    logic [3:0]  event_code;

    logic [3:0] mem [0:MSZ-1];
    int checks = 0;
    int failures = 0;
    int exp_addr [0:3];
    int exp_blk, exp_evt;

    collision_probe_sequencer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .blocked   (blocked),
        .event_code(event_code)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Single-port RAM with one cycle of read latency.
    always @(posedge Clk) rd_data <= (int'(rd_addr) < MSZ) ? mem[rd_addr] : 4'h0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: evaluate the four hitbox corners directly from the map contents.
    task automatic model(input int x, input int y);
        exp_blk = 0;
        exp_evt = 0;
        for (int c = 0; c < 4; c++) begin
            int cx, cy;
            bit o;
            cx = x + (((c & 1) != 0) ? 15 : 0);
            cy = y + (((c & 2) != 0) ? 15 : 0);
            o  = (cx >= MW) || (cy >= MH);
            exp_addr[c] = o ? 0 : cy * MW + cx;
            if (o) exp_blk = 1;
            else begin
                if (mem[exp_addr[c]] == 4'h1) exp_blk = 1;
                if (exp_evt == 0 && mem[exp_addr[c]] >= 4'd2) exp_evt = int'(mem[exp_addr[c]]);
            end
        end
    endtask

    // Put random codes at the in-bounds corners of a position.
    task automatic seed_corners(input int x, input int y);
        for (int c = 0; c < 4; c++) begin
            int cx, cy, r;
            cx = x + (((c & 1) != 0) ? 15 : 0);
            cy = y + (((c & 2) != 0) ? 15 : 0);
            if (cx < MW && cy < MH) begin
                r = $urandom_range(0, 3);
                mem[cy * MW + cx] = (r == 0) ? 4'h0 : (r == 1) ? 4'h1 : 4'($urandom_range(0, 15));
            end
        end
    endtask

    // Caller is at a negedge; drives start there, ends at the negedge seven cycles later.
    task automatic probe(input int x, input int y, input bit repulse);
        model(x, y);
        start = 1'b1;
        pos_x = 10'(x);
        pos_y = 9'(y);
        @(negedge Clk);
        start = 1'b0;
        pos_x = 10'($urandom);
        pos_y = 9'($urandom);
        for (int cyc = 1; cyc <= 6; cyc++) begin
            chk($sformatf("busy c%0d", cyc), int'(busy), 1);
            chk($sformatf("done c%0d", cyc), int'(done), (cyc == 6) ? 1 : 0);
            if (cyc <= 4) chk($sformatf("addr corner%0d", cyc - 1), int'(rd_addr), exp_addr[cyc - 1]);
            if (cyc == 6) begin
                chk("blocked", int'(blocked), exp_blk);
                chk("event_code", int'(event_code), exp_evt);
            end
            if (repulse) start = (cyc < 6) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge Clk);
        end
        start = 1'b0;
        chk("busy after done", int'(busy), 0);
        chk("done after done", int'(done), 0);
        chk("blocked hold", int'(blocked), exp_blk);
        chk("event hold", int'(event_code), exp_evt);
    endtask

    initial begin
        Reset_n = 1'b0;
        start   = 1'b0;
        pos_x   = '0;
        pos_y   = '0;
        for (int i = 0; i < MSZ; i++) mem[i] = 4'h0;
        #12;
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst blocked", int'(blocked), 0);
        chk("rst event", int'(event_code), 0);
        chk("rst addr", int'(rd_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Clear probe
        probe(100, 50, 1'b0);
        // Wall on c3
        mem[20915] = 4'h1;
        probe(100, 50, 1'b0);
        // Events on c1 and c2: lowest-index wins
        mem[20915] = 4'h0;
        mem[16115] = 4'h3;
        mem[20900] = 4'h2;
        probe(100, 50, 1'b0);
        mem[16115] = 4'h0;
        mem[20900] = 4'h0;
        // Right-edge OOB
        probe(310, 0, 1'b0);
        // Bottom-edge and corner OOB; OOB data must be ignored even if nonzero
        mem[0] = 4'h5;
        probe(0, 230, 1'b0);
        probe(1000, 500, 1'b0);
        mem[0] = 4'h0;
        // Last fully in-bounds position
        mem[224 * MW + 304] = 4'h7;
        probe(304, 224, 1'b0);
        // Re-pulsed start during busy, then back-to-back at cycle 7
        probe(100, 50, 1'b1);
        probe(20, 30, 1'b0);

        // Reset mid-probe
        mem[50 * MW + 100] = 4'h1;
        start = 1'b1;
        pos_x = 10'd100;
        pos_y = 9'd50;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid blocked pre-reset", int'(blocked), 1);
        Reset_n = 1'b0;
        #1;
        chk("mid rst busy", int'(busy), 0);
        chk("mid rst done", int'(done), 0);
        chk("mid rst blocked", int'(blocked), 0);
        chk("mid rst addr", int'(rd_addr), 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            chk("post rst no done", int'(done), 0);
            chk("post rst idle", int'(busy), 0);
        end
        mem[50 * MW + 100] = 4'h0;
        probe(100, 50, 1'b0);

        // Randomized probes
        for (int t = 0; t < 40; t++) begin
            int x, y;
            x = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 330);
            y = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 250);
            seed_corners(x, y);
            probe(x, y, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge Clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
